key_hex_counter: RTL and testbench
==================================

// Module: key_hex_counter
// PURPOSE
//  Debounced pushbutton-driven 4-bit hex up/down counter. Sits directly upstream of the
//  7-segment decoder: COUNT drives the decoder's 4-bit number input, one digit per instance.
//  Turns a bouncy active-low KEY into single clean steps, and supports parallel load from SW.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles needed to accept a key change (20 ms @ 50 MHz)
//  REPEAT_DELAY     25_000_000 cycles held before first auto-repeat step (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    10_000_000 cycles between subsequent auto-repeat steps (AUTO_REPEAT_EN only)
// PORTS
//  CLOCK_50  in   1  system clock, all state on rising edge
//  RST_N     in   1  asynchronous active-low reset
//  KEY_N     in   1  raw step pushbutton, active-low, asynchronous, bouncy
//  UP        in   1  direction: 1 = increment, 0 = decrement (SW level, sampled at step)
//  LOAD      in   1  synchronous load enable (SW level)
//  LOAD_VAL  in   4  value loaded when LOAD=1
//  COUNT     out  4  current digit, to 7-segment decoder
//  WRAP      out  1  one-cycle pulse on 4'hF->4'h0 (up) or 4'h0->4'hF (down)
//  PRESSED   out  1  debounced key level, 1 = held down
// BEHAVIOUR
//  - Reset (RST_N=0, async): COUNT=0, WRAP=0, PRESSED=0, sync FFs=1, debounce cnt=0, FSM=RELEASED.
//  - KEY_N passes through 2-FF synchroniser (reset value 1) before any use.
//  - Debounce FSM: RELEASED -> ARM_PRESS when synced key=0; ARM_PRESS counts cycles, returns to
//    RELEASED (cnt cleared) on any synced 1; at cnt==DEBOUNCE_CYCLES-1 -> HELD, PRESSED<=1, step pulse.
//    HELD -> ARM_RELEASE when synced key=1; same counting, bounce back to HELD clears cnt;
//    at DEBOUNCE_CYCLES-1 -> RELEASED, PRESSED<=0. Release never steps.
//  - Latency: KEY_N held low from edge E -> COUNT updates at edge E+DEBOUNCE_CYCLES+2.
//  - Step: COUNT <= COUNT+1 (UP=1) or COUNT-1 (UP=0), mod 16; WRAP=1 same cycle COUNT wraps.
//  - LOAD priority: while LOAD=1, COUNT<=LOAD_VAL every cycle; coincident steps dropped, WRAP=0.
//    Debounce FSM keeps running during LOAD (key state still tracked).
//  - UP change mid-hold has no effect until next step.
//  - Exactly one step per accepted press regardless of hold length (without AUTO_REPEAT_EN).
//  - Reset mid-debounce aborts count; key held through reset release must re-qualify
//    a full DEBOUNCE_CYCLES before stepping.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in HELD, a repeat timer counts; extra step at REPEAT_DELAY cycles
//    after entering HELD, then every REPEAT_PERIOD; timer clears on leaving HELD or LOAD=1.
//  AUTO_REPEAT_EN undefined: no repeat timer logic; REPEAT_* parameters unused.
// STRUCTURE
//  Package key_hex_pkg: FSM state enum (RELEASED, ARM_PRESS, HELD, ARM_RELEASE),
//    DIGIT_W=4, DIGIT_MAX=4'hF.
//  Sub-module key_debounce: synchroniser + FSM + cnt; outputs PRESSED level and 1-cycle press pulse.
//  Top: counter/load/wrap logic and optional repeat timer.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset: RST_N low mid-run -> COUNT=0, WRAP=0, PRESSED=0 immediately, no clock needed.
//  2 Clean press UP=1 from 0: KEY_N low at edge E, held 20 cycles -> COUNT=1 at E+6, stays 1;
//    PRESSED=1 at E+6, 0 four cycles after synced release.
//  3 Bounce: KEY_N low 2 cycles, high 1, low 2, high -> COUNT unchanged, PRESSED never 1.
//  4 Wrap: LOAD_VAL=4'hF load, then UP=1 press -> COUNT=0, WRAP pulses 1 cycle;
//    UP=0 press -> COUNT=F, WRAP pulse.
//  5 LOAD vs step: LOAD=1 LOAD_VAL=4'h7 on the step cycle -> COUNT=7, WRAP=0, no step after.
//  6 AUTO_REPEAT_EN: hold key 30 cycles past acceptance from 0, UP=1 -> steps at +0,+10,+13,
//    +16... (COUNT=8); without macro COUNT=1.

Source files
------------

// File: rtl/key_hex_pkg.sv
// Shared types for the debounced hex digit counter: key FSM states, digit width and step helpers.
// Pure declarations and functions; no clocked logic.
package key_hex_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'hF;

  typedef enum logic [1:0] {
    RELEASED,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } key_state_e;

  function automatic digit_t step_digit(digit_t val, logic up);
    return up ? val + 1'b1 : val - 1'b1;
  endfunction

  function automatic logic step_wraps(digit_t val, logic up);
    return up ? (val == DIGIT_MAX) : (val == '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// 2-FF synchroniser plus press/release qualifier; accepted press pulses combinationally on the edge PRESSED rises.
// Latency: key low at edge E -> pressed_o/press_pulse_o effective at edge E+DEBOUNCE_CYCLES+2; no backpressure.
module key_debounce
  import key_hex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic held_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;

  // Idle level of an active-low key is 1, so reset the synchroniser there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pressed_d     = pressed_q;
    press_pulse_o = 1'b0;
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (!sync2_q) state_d = ARM_PRESS;
      end
      ARM_PRESS: begin
        if (sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          pressed_d     = 1'b1;
          press_pulse_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (sync2_q) state_d = ARM_RELEASE;
      end
      ARM_RELEASE: begin
        if (!sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_o = pressed_q;
  assign held_o    = (state_q == HELD);

endmodule

// File: rtl/key_hex_counter.sv
// Debounced pushbutton hex up/down digit with parallel load; COUNT steps at edge E+DEBOUNCE_CYCLES+2, no backpressure.
// Optional auto-repeat while held is built only when AUTO_REPEAT_EN is defined.
module key_hex_counter
  import key_hex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic               KEY_N,
  input  logic               UP,
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] LOAD_VAL,
  output logic [DIGIT_W-1:0] COUNT,
  output logic               WRAP,
  output logic               PRESSED
);

  logic   press_pulse;
  logic   held;
  logic   rep_step;
  logic   step;
  digit_t count_q, count_d;
  logic   wrap_q, wrap_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i        (CLOCK_50),
    .rst_ni       (RST_N),
    .key_ni       (KEY_N),
    .pressed_o    (PRESSED),
    .press_pulse_o(press_pulse),
    .held_o       (held)
  );

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] rep_limit;
  logic             rep_armed_q, rep_armed_d;

  // First repeat waits the long delay; once armed, the short period applies.
  assign rep_limit = rep_armed_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_step    = 1'b0;
    if (!held || LOAD) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (rep_cnt_q == rep_limit) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b1;
      rep_step    = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end
`else
  localparam int unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_held;
  assign unused_held = held;
  assign rep_step    = 1'b0;
`endif

  assign step = press_pulse | rep_step;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (LOAD) begin
      count_d = LOAD_VAL;
    end else if (step) begin
      count_d = step_digit(count_q, UP);
      wrap_d  = step_wraps(count_q, UP);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_key_hex_counter.sv
// Randomised and directed bench for key_hex_counter against a run-length/elapsed-time reference model.
module tb_key_hex_counter;
  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic       KEY_N;
  logic       UP;
  logic       LOAD;
  logic [3:0] LOAD_VAL;
  wire  [3:0] COUNT;
  wire        WRAP;
  wire        PRESSED;

  key_hex_counter #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .KEY_N   (KEY_N),
    .UP      (UP),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .COUNT   (COUNT),
    .WRAP    (WRAP),
    .PRESSED (PRESSED)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;
  int auto_rep = 0;
  int wraps_seen;
  int pressed_seen;

  // Reference model: raw key delay line, run length of the opposite level, hold time.
  int m_s1, m_s2, m_pressed, m_run, m_count, m_wrap, m_el;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_pressed = 0; m_run = 0;
    m_count = 0; m_wrap = 0; m_el = 0;
  endtask

  task automatic model_edge();
    int down, was_held, step, rep;
    down     = (m_s2 == 0);
    was_held = (m_pressed == 1 && m_run == 0);
    step = 0; rep = 0;
    m_s2 = m_s1;
    m_s1 = int'(KEY_N);
    if (down != m_pressed) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_pressed = down;
        m_run = 0;
        step = down;
      end
    end else begin
      m_run = 0;
    end
    if (auto_rep != 0 && was_held != 0 && !LOAD) begin
      m_el++;
      rep = (m_el >= RDLY) && ((m_el - RDLY) % RPER == 0);
    end else begin
      m_el = 0;
    end
    if (LOAD) begin
      m_count = int'(LOAD_VAL);
      m_wrap  = 0;
    end else if (step != 0 || rep != 0) begin
      m_wrap  = UP ? (m_count == 15) : (m_count == 0);
      m_count = UP ? (m_count + 1) % 16 : (m_count + 15) % 16;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      check("count", int'(COUNT), m_count);
      check("wrap", int'(WRAP), m_wrap);
      check("pressed", int'(PRESSED), m_pressed);
      if (WRAP) wraps_seen++;
      if (PRESSED) pressed_seen++;
    end
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    #1;
    check("rst_count", int'(COUNT), 0);
    check("rst_wrap", int'(WRAP), 0);
    check("rst_pressed", int'(PRESSED), 0);
    model_reset();
    @(negedge CLOCK_50);
    #2 RST_N = 1'b1;
  endtask

  initial begin
    int n, c0;
`ifdef AUTO_REPEAT_EN
    auto_rep = 1;
`endif
    RST_N = 1'b0; KEY_N = 1'b1; UP = 1'b1; LOAD = 1'b0; LOAD_VAL = 4'h0;
    wraps_seen = 0; pressed_seen = 0;
    model_reset();
    #3;
    check("rst0_count", int'(COUNT), 0);
    check("rst0_pressed", int'(PRESSED), 0);
    @(negedge CLOCK_50);
    RST_N = 1'b1;
    run_cycles(3);

    // Clean press: latency to first step and release qualification.
    UP = 1'b1; KEY_N = 1'b0;
    run_cycles(6);
    check("lat_pre", int'(COUNT), 0);
    run_cycles(1);
    check("lat_count", int'(COUNT), 1);
    check("lat_pressed", int'(PRESSED), 1);
    run_cycles(13);
    KEY_N = 1'b1;
    n = 0;
    while (PRESSED && n < 50) begin
      run_cycles(1);
      n++;
    end
    check("rel_lat", n, 7);
    run_cycles(3);

    // Bounce shorter than the qualification window.
    c0 = m_count; pressed_seen = 0;
    KEY_N = 1'b0; run_cycles(2);
    KEY_N = 1'b1; run_cycles(1);
    KEY_N = 1'b0; run_cycles(2);
    KEY_N = 1'b1; run_cycles(8);
    check("bounce_pressed", pressed_seen, 0);
    check("bounce_count", int'(COUNT), c0);

    // Wrap both directions.
    LOAD = 1'b1; LOAD_VAL = 4'hF; run_cycles(1);
    LOAD = 1'b0; UP = 1'b1; wraps_seen = 0;
    KEY_N = 1'b0; run_cycles(8);
    KEY_N = 1'b1; run_cycles(8);
    check("wrap_up_count", int'(COUNT), 0);
    check("wrap_up_pulses", wraps_seen, 1);
    UP = 1'b0; wraps_seen = 0;
    KEY_N = 1'b0; run_cycles(8);
    KEY_N = 1'b1; run_cycles(8);
    check("wrap_dn_count", int'(COUNT), 15);
    check("wrap_dn_pulses", wraps_seen, 1);

    // Load coinciding with the accepting edge wins.
    UP = 1'b1; LOAD_VAL = 4'h7;
    KEY_N = 1'b0; run_cycles(6);
    LOAD = 1'b1; run_cycles(1);
    check("load_count", int'(COUNT), 7);
    check("load_wrap", int'(WRAP), 0);
    LOAD = 1'b0; run_cycles(6);
    KEY_N = 1'b1; run_cycles(8);
    check("load_nostep", int'(COUNT), 7);

    // Long hold: auto-repeat when built in, single step otherwise.
    LOAD = 1'b1; LOAD_VAL = 4'h0; run_cycles(1);
    LOAD = 1'b0; UP = 1'b1;
    KEY_N = 1'b0; run_cycles(7);
    run_cycles(30);
    check("repeat_count", int'(COUNT), (auto_rep != 0) ? 8 : 1);
    KEY_N = 1'b1; run_cycles(10);

    // Reset mid-debounce with the key held: must re-qualify from scratch.
    KEY_N = 1'b0; run_cycles(4);
    do_reset();
    run_cycles(6);
    check("requal_pre_count", int'(COUNT), 0);
    check("requal_pre_pressed", int'(PRESSED), 0);
    run_cycles(1);
    check("requal_count", int'(COUNT), 1);
    check("requal_pressed", int'(PRESSED), 1);
    KEY_N = 1'b1; run_cycles(10);

    // Random segments of key level, direction and load.
    for (int s = 0; s < 300; s++) begin
      KEY_N = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) UP = 1'($urandom_range(0, 1));
      LOAD = ($urandom_range(0, 15) == 0);
      LOAD_VAL = 4'($urandom_range(0, 15));
      if (s == 150) do_reset();
      run_cycles($urandom_range(1, 14));
    end
    LOAD = 1'b0; KEY_N = 1'b1;
    run_cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
